// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer that issues word-aligned memory accesses and read-modify-writes byte stores.
module mem_access_unit #(
    parameter bit          ERR_ON_MISALIGN = 1'b1,
    parameter logic [15:0] RESET_RDATA     = 16'h0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_size,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] addrm,
    output logic [15:0] wmdata,
    output logic        re,
    output logic        we,
    output logic        mem_alu,
    input  logic [15:0] rwdata
);
    typedef enum logic [2:0] {IDLE, LOAD, WSTORE, RMW_RD, RMW_WR, RESP} state_t;
    state_t     state;
    logic       size_q;
    logic       signed_q;
    logic       lo_q;
    logic [7:0] byte_sel;
    logic       misaligned;
    assign req_ready  = state == IDLE;
    assign mem_alu    = 1'b0;
    assign byte_sel   = lo_q ? rwdata[15:8] : rwdata[7:0];
    assign misaligned = ERR_ON_MISALIGN && req_size && req_addr[0];
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            size_q     <= 1'b0;
            signed_q   <= 1'b0;
            lo_q       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= RESET_RDATA;
            addrm      <= 16'h0000;
            wmdata     <= 16'h0000;
            re         <= 1'b0;
            we         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addrm    <= {req_addr[15:1], 1'b0};
                    wmdata   <= req_wdata;
                    size_q   <= req_size;
                    signed_q <= req_signed;
                    lo_q     <= req_addr[0];
                    if (misaligned) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= RESET_RDATA;
                    end else if (!req_we) begin
                        state <= LOAD;
                        re    <= 1'b1;
                    end else if (req_size) begin
                        state <= WSTORE;
                        we    <= 1'b1;
                    end else begin
                        state <= RMW_RD;
                        re    <= 1'b1;
                    end
                end
                LOAD: begin
                    re         <= 1'b0;
                    resp_rdata <= size_q ? rwdata : {{8{signed_q & byte_sel[7]}}, byte_sel};
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_RD: begin
                    // wmdata still holds the store byte in [7:0]; splice it into the lane being written
                    re     <= 1'b0;
                    we     <= 1'b1;
                    wmdata <= lo_q ? {wmdata[7:0], rwdata[7:0]} : {rwdata[15:8], wmdata[7:0]};
                    state  <= RMW_WR;
                end
                WSTORE, RMW_WR: begin
                    we         <= 1'b0;
                    resp_rdata <= 16'h0000;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors against a byte-array memory model; second instance covers ERR_ON_MISALIGN=0.
module tb_mem_access_unit;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    logic        req_valid = 1'b0, req_valid0 = 1'b0, req_we = 1'b0, req_size = 1'b0, req_signed = 1'b0;
    logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
    logic        resp_ready = 1'b1;
    logic        req_ready, resp_valid, resp_err, re, we, mem_alu;
    logic [15:0] resp_rdata, addrm, wmdata, rwdata;
    logic        req_ready0, resp_valid0, resp_err0, re0, we0, mem_alu0;
    logic [15:0] resp_rdata0, addrm0, wmdata0, rwdata0;

    logic [7:0] mem [0:255];
    assign rwdata  = {mem[{addrm[7:1], 1'b1}], mem[{addrm[7:1], 1'b0}]};
    assign rwdata0 = {mem[{addrm0[7:1], 1'b1}], mem[{addrm0[7:1], 1'b0}]};

    mem_access_unit dut (
        .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .addrm(addrm), .wmdata(wmdata),
        .re(re), .we(we), .mem_alu(mem_alu), .rwdata(rwdata)
    );

    mem_access_unit #(.ERR_ON_MISALIGN(1'b0)) dut0 (
        .clock(clock), .resetn(resetn), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0), .addrm(addrm0), .wmdata(wmdata0),
        .re(re0), .we(we0), .mem_alu(mem_alu0), .rwdata(rwdata0)
    );

    int re_cnt = 0, we_cnt = 0, both = 0, re0_cnt = 0, we0_cnt = 0;
    logic [15:0] re_addr = 16'h0, we_addr = 16'h0, we_data = 16'h0, re0_addr = 16'h0;
    always @(posedge clock) begin
        if (re) begin
            re_cnt  <= re_cnt + 1;
            re_addr <= addrm;
        end
        if (we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= addrm;
            we_data <= wmdata;
            mem[{addrm[7:1], 1'b0}] <= wmdata[7:0];
            mem[{addrm[7:1], 1'b1}] <= wmdata[15:8];
        end
        if ((re && we) || (re0 && we0)) both <= both + 1;
        if (re0) begin
            re0_cnt  <= re0_cnt + 1;
            re0_addr <= addrm0;
        end
        if (we0) we0_cnt <= we0_cnt + 1;
    end

    int checks = 0, failures = 0;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic s, input logic sg, input logic [15:0] a,
                        input logic [15:0] d, output int lat);
        int n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        req_valid = 1'b1; req_we = w; req_size = s; req_signed = sg; req_addr = a; req_wdata = d;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clock);
            #1 lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, r0, w0;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h10] <= 8'h34; mem[8'h11] <= 8'h12;
        mem[8'h20] <= 8'hC3; mem[8'h21] <= 8'h85;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 16'h0000);
        check("rst_re_we", {re, we, mem_alu}, 0);
        check("rst_addrm", addrm, 16'h0000);
        check("rst_wmdata", wmdata, 16'h0000);
        @(negedge clock) resetn = 1'b1;

        xfer(0, 1, 0, 16'h0010, 16'h0, lat);
        check("ld_w_lat", lat, 2);
        check("ld_w_data", resp_rdata, 16'h1234);
        check("ld_w_err", resp_err, 0);
        check("ld_w_re_cnt", re_cnt, 1);
        check("ld_w_re_addr", re_addr, 16'h0010);
        check("ld_w_we_cnt", we_cnt, 0);

        xfer(0, 0, 0, 16'h0021, 16'h0, lat);
        check("ld_b_hi_u", resp_rdata, 16'h0085);
        xfer(0, 0, 1, 16'h0021, 16'h0, lat);
        check("ld_b_hi_s", resp_rdata, 16'hFF85);
        xfer(0, 0, 0, 16'h0020, 16'h0, lat);
        check("ld_b_lo_u", resp_rdata, 16'h00C3);
        xfer(0, 0, 1, 16'h0020, 16'h0, lat);
        check("ld_b_lo_s", resp_rdata, 16'hFFC3);
        check("ld_b_err", resp_err, 0);

        r0 = re_cnt; w0 = we_cnt;
        xfer(1, 0, 0, 16'h0011, 16'h00AB, lat);
        check("st_b_hi_lat", lat, 3);
        check("st_b_hi_rdata", resp_rdata, 16'h0000);
        check("st_b_hi_re", re_cnt - r0, 1);
        check("st_b_hi_we", we_cnt - w0, 1);
        check("st_b_hi_wmdata", we_data, 16'hAB34);
        check("st_b_hi_addr", we_addr, 16'h0010);
        xfer(0, 1, 0, 16'h0010, 16'h0, lat);
        check("st_b_hi_readback", resp_rdata, 16'hAB34);

        xfer(1, 0, 0, 16'h0010, 16'h77CD, lat);
        check("st_b_lo_wmdata", we_data, 16'hABCD);
        xfer(0, 1, 0, 16'h0010, 16'h0, lat);
        check("st_b_lo_readback", resp_rdata, 16'hABCD);

        r0 = re_cnt;
        xfer(1, 1, 0, 16'h0012, 16'h5678, lat);
        check("st_w_lat", lat, 2);
        check("st_w_wmdata", we_data, 16'h5678);
        check("st_w_no_re", re_cnt - r0, 0);
        check("st_w_rdata", resp_rdata, 16'h0000);
        xfer(0, 1, 0, 16'h0012, 16'h0, lat);
        check("st_w_readback", resp_rdata, 16'h5678);

        r0 = re_cnt; w0 = we_cnt;
        xfer(0, 1, 0, 16'h0013, 16'h0, lat);
        check("mis_lat", lat, 1);
        check("mis_err", resp_err, 1);
        check("mis_rdata", resp_rdata, 16'h0000);
        @(posedge clock);
        #1;
        check("mis_no_access", {re_cnt - r0, we_cnt - w0}, 0);
        check("mis_err_clear", {resp_valid, resp_err}, 0);

        @(negedge clock);
        req_valid0 = 1'b1; req_we = 1'b0; req_size = 1'b1; req_addr = 16'h0013;
        @(posedge clock);
        #1 req_valid0 = 1'b0;
        lat = 1;
        while (!resp_valid0 && lat < 20) begin
            @(posedge clock);
            #1 lat++;
        end
        check("mis0_lat", lat, 2);
        check("mis0_err", resp_err0, 0);
        check("mis0_rdata", resp_rdata0, 16'h5678);
        check("mis0_addrm", re0_addr, 16'h0012);
        check("mis0_re_cnt", re0_cnt, 1);

        resp_ready = 1'b0;
        xfer(0, 1, 0, 16'h0010, 16'h0, lat);
        r0 = re_cnt;
        @(negedge clock);
        req_valid = 1'b1; req_size = 1'b0; req_addr = 16'h0020;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("stall_hold", {resp_valid, req_ready, resp_rdata}, {1'b1, 1'b0, 16'hABCD});
        end
        check("stall_no_accept", re_cnt - r0, 0);
        @(negedge clock);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clock);
        #1;
        check("stall_release", {resp_valid, req_ready}, 2'b01);
        check("stall_no_accept2", re_cnt - r0, 0);

        w0 = we_cnt;
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_size = 1'b0; req_addr = 16'h0011; req_wdata = 16'h0011;
        @(posedge clock);
        #1 req_valid = 1'b0;
        check("rmw_in_rd", {re, we}, 2'b10);
        resetn = 1'b0;
        #1;
        check("rmw_rst_outs", {re, we, resp_valid, req_ready, addrm, wmdata}, {4'b0001, 32'h0});
        repeat (2) @(posedge clock);
        @(negedge clock) resetn = 1'b1;
        @(posedge clock);
        #1;
        check("rmw_rst_no_we", we_cnt - w0, 0);
        check("rmw_rst_mem", mem[8'h11], 8'hAB);
        xfer(0, 1, 0, 16'h0010, 16'h0, lat);
        check("rmw_rst_readback", resp_rdata, 16'hABCD);

        check("re_we_exclusive", both, 0);
        check("dut0_no_we", we0_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
